// File: rtl/lcd_spi_tx_if.sv
// lcd_spi_tx_if: word handshake into the ST7789V SPI serializer.
// Carries one {last, dc, data} word per valid/ready transfer.
interface lcd_spi_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_dc;
    logic [7:0] in_data;
    logic       in_last;

    modport master (
        output in_valid, in_dc, in_data, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_dc, in_data, in_last,
        output in_ready
    );
endinterface

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: FIFO-buffered write-only SPI serializer for the ST7789V.
// Bytes go out MSB first; CS stays low across non-last bytes.
module lcd_spi_tx #(
    parameter int DIV        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    lcd_spi_tx_if.slave bus,
    output logic        busy,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_sck,
    output logic        lcd_sda
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(2 * DIV) + 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_M1 = CW'(2 * DIV - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, HIGH, LOW, WAIT, CSHOLD, GAP
    } state_t;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_d;
    logic          full, empty, push, pop;
    logic [9:0]    head;

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic          done, moved;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          last_q, last_d;
    logic          cs_d, rs_d, sck_d, sda_d, busy_d;

    assign full         = (count == NW'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign bus.in_ready = ~full & ~rst;
    assign push         = bus.in_valid & bus.in_ready;
    assign head         = mem[rd_ptr];
    assign count_d      = count + NW'(push) - NW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.in_last, bus.in_dc, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
        end
    end

    assign done  = (state == GAP) ? (cnt == GAP_M1) : (cnt == DIV_M1);
    assign moved = (nstate != state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh_q    <= '0;
            last_q  <= 1'b0;
            lcd_cs  <= 1'b1;
            lcd_rs  <= 1'b1;
            lcd_sck <= 1'b0;
            lcd_sda <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= nstate;
            cnt     <= moved ? '0 : cnt + CW'(1);
            bit_idx <= bit_d;
            sh_q    <= sh_d;
            last_q  <= last_d;
            lcd_cs  <= cs_d;
            lcd_rs  <= rs_d;
            lcd_sck <= sck_d;
            lcd_sda <= sda_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        unique case (state)
            IDLE, WAIT: begin
                if (!empty) begin
                    pop    = 1'b1;
                    nstate = LOAD;
                end
            end
            LOAD: if (done) nstate = HIGH;
            LOW:  if (done) nstate = HIGH;
            HIGH: begin
                // last bit chains straight into the next LOAD
                if (done) begin
                    if (bit_idx != 3'd0) begin
                        nstate = LOW;
                    end else if (last_q) begin
                        nstate = CSHOLD;
                    end else if (!empty) begin
                        pop    = 1'b1;
                        nstate = LOAD;
                    end else begin
                        nstate = WAIT;
                    end
                end
            end
            CSHOLD: if (done) nstate = GAP;
            GAP:    if (done) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        cs_d   = lcd_cs;
        rs_d   = lcd_rs;
        sck_d  = lcd_sck;
        sda_d  = lcd_sda;
        sh_d   = sh_q;
        bit_d  = bit_idx;
        last_d = last_q;
        unique case (1'b1)
            pop: begin
                cs_d   = 1'b0;
                rs_d   = head[8];
                sck_d  = 1'b0;
                sda_d  = head[7];
                sh_d   = head[7:0];
                bit_d  = 3'd7;
                last_d = head[9];
            end
            moved && nstate == HIGH: sck_d = 1'b1;
            moved && nstate == LOW: begin
                sck_d = 1'b0;
                sda_d = sh_q[bit_idx - 3'd1];
                bit_d = bit_idx - 3'd1;
            end
            moved && (nstate == WAIT || nstate == CSHOLD):
                sck_d = 1'b0;
            moved && nstate == GAP: begin
                cs_d  = 1'b1;
                rs_d  = 1'b1;
                sda_d = 1'b1;
            end
            moved && nstate == IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
            end
            default: ;
        endcase
        busy_d = (count_d != '0) | (nstate != IDLE);
    end
endmodule

// File: doc/lcd_spi_tx.md
Name: lcd_spi_tx

Overview:
- Write-only SPI serializer for the ST7789V panel, directly downstream of the LCD init/pixel sequencer.
- Accepts 9-bit words ({dc, byte}) over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each byte MSB-first on lcd_sda with a divided lcd_sck, and drives lcd_cs/lcd_rs per byte.
- Replaces the sequencer's inline bit_loop shifting so init commands and pixels share one transmit path.

Parameters:
DIV, 1, SCK half-period in clk cycles (>=1); one byte takes 16*DIV cycles.
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  word offered
in_ready  out  1  FIFO can accept a word this cycle
in_dc  in  1  lcd_rs value for this byte (0=command, 1=data)
in_data  in  8  byte to send, MSB first
in_last  in  1  release CS after this byte
busy  out  1  FIFO non-empty or FSM not IDLE
lcd_cs  out  1  chip select, active low
lcd_rs  out  1  data/command select
lcd_sck  out  1  SPI clock, idle low, panel samples on rising edge
lcd_sda  out  1  serial data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: lcd_cs=1, lcd_rs=1, lcd_sck=0, lcd_sda=1, busy=0. All outputs are registered.
- FIFO:
  - Entry is {last, dc, data}.
  - in_ready = ~full & ~rst, derived from the registered count.
  - A push occurs when in_valid & in_ready. in_valid while in_ready=0 is ignored; no overwrite.
  - Push and pop in the same cycle are allowed. When full, the push is refused even if a pop happens that cycle.
  - Pop is attempted only when empty=0.
- FSM states: IDLE, LOAD, HIGH, LOW, WAIT, CSHOLD, GAP. A phase counter counts DIV cycles.
- IDLE: lcd_cs=1, lcd_sck=0. FIFO non-empty -> pop -> LOAD.
- LOAD (DIV cycles):
  - lcd_cs=0; lcd_rs=dc and lcd_sda=data[7], both set on entry; lcd_sck=0. Bit index = 7.
  - Then -> HIGH.
- HIGH (DIV cycles): lcd_sck=1, lcd_sda and lcd_rs held.
  - Bit index > 0 -> LOW.
  - Bit index = 0: if last=1 -> CSHOLD.
  - Bit index = 0, last=0, FIFO non-empty -> pop -> LOAD, with CS staying low.
  - Bit index = 0, last=0, FIFO empty -> WAIT.
- LOW (DIV cycles): lcd_sck=0; lcd_sda = next bit, updated on entry. Then -> HIGH.
- WAIT: lcd_cs=0, lcd_sck=0, lcd_sda and lcd_rs held. FIFO non-empty -> pop -> LOAD. No timeout.
- CSHOLD (DIV cycles): lcd_sck=0, lcd_cs=0. Then -> GAP.
- GAP (2*DIV cycles): lcd_cs=1, lcd_rs=1, lcd_sda=1. Then -> IDLE. A queued word waits out the full GAP.
- Timing:
  - Back-to-back non-last bytes give exactly 16*DIV cycles per byte, 8 rising edges each, with no SCK gap.
  - Latency from push into an empty FIFO in IDLE to lcd_cs falling: 2 cycles (FIFO write, then pop/LOAD).
- lcd_rs changes only on LOAD entry or in GAP, never while lcd_sck=1.
- Reset mid-byte: on the next clk edge all outputs take reset values, the FIFO is flushed, the FSM goes to IDLE, and the partial byte is dropped.

Test Plan:
1. DIV=1: push {dc=0, 0x11, last=1} -> cs low for 16+1 cycles; sda at the 8 sck rising edges = 0,0,0,1,0,0,0,1; rs=0 throughout; then cs high 2 cycles; busy falls in IDLE.
2. DIV=1: push {0x0,0x2A,0} then {1,0x00,0},{1,0x28,1} back-to-back -> cs continuously low for 48+1 cycles; rs=0 for the first 8 edges, 1 for the next 16; sck period is exactly 2 cycles with no gap between bytes.
3. Pixel 0xF800 as {1,0xF8,0},{1,0x00,1} with DIV=3 -> sck high 3 / low 3; 16 edges carry 1111100000000000; cs high for 6 cycles afterwards.
4. Hold in_valid with 6 words while the first shifts -> in_ready drops after 4 stored words, plus the one popped; no word is lost or duplicated; output order is preserved.
5. Push {0,0x36,0}, wait 40 cycles, push {1,0x70,1} -> WAIT with cs=0, sck=0 for the gap; the second byte follows with no cs pulse.
6. Assert rst at the 4th rising edge of a byte with 2 words queued -> next cycle cs=1, sck=0, sda=1, busy=0, and no further sck edges.
